control_muxn_stream: RTL and testbench

- Parametrised N-way successor to the 2:1 stream-mux reset controller in the matrix_mult datapath.
- Steps a round-robin channel select across NUM_CH input streams, dwelling DWELL cycles on each channel.
- Holds every non-selected channel in reset.
- Adds a start/busy/done handshake, a run-time round count, stall and abort; feeds the systolic-array input muxes.

---
 rtl/control_mux_pkg.sv | 17 +
 rtl/control_muxn_stream_if.sv | 29 ++
 rtl/control_mux_dwell_cnt.sv | 67 ++++++
 rtl/control_muxn_stream.sv | 75 +++++++
 tb/tb_control_muxn_stream.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_mux_pkg.sv
// rtl/control_mux_pkg.sv - shared types and helpers for the N-way stream-mux reset controller
package control_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [255:0] CH_RESET_ALL = '1;

    // A single channel still needs a one-bit select.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/control_muxn_stream_if.sv
// rtl/control_muxn_stream_if.sv - control/status bundle between sequencer and its user
interface control_muxn_stream_if
    import control_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int RND_W  = 8
) ();
    localparam int SEL_W = sel_w(NUM_CH);

    logic              start;
    logic [RND_W-1:0]  cfg_rounds;
    logic              stall;
    logic              abort;
    logic [SEL_W-1:0]  ch_sel;
    logic [NUM_CH-1:0] ch_reset;
    logic              ch_first;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_rounds, stall, abort,
        input  ch_sel, ch_reset, ch_first, busy, done
    );

    modport slave (
        input  start, cfg_rounds, stall, abort,
        output ch_sel, ch_reset, ch_first, busy, done
    );
endinterface

// File: rtl/control_mux_dwell_cnt.sv
// rtl/control_mux_dwell_cnt.sv - dwell/channel/round counter chain with enable, clear and wrap
module control_mux_dwell_cnt
    import control_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DWELL  = 4,
    parameter int RND_W  = 8,
    parameter int SEL_W  = sel_w(NUM_CH),
    parameter int DW_W   = sel_w(DWELL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] ch_sel_o,
    output logic             first_o,
    output logic [RND_W-1:0] round_cnt_o,
    output logic             wrap_o
);
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             dwell_end, ch_end;

    assign dwell_end = (dwell_q == DW_W'(DWELL - 1));
    assign ch_end    = (sel_q == SEL_W'(NUM_CH - 1));

    always_comb begin
        dwell_d = dwell_q;
        sel_d   = sel_q;
        rnd_d   = rnd_q;
        if (clr_i) begin
            dwell_d = '0;
            sel_d   = '0;
            rnd_d   = '0;
        end else if (en_i) begin
            if (dwell_end) begin
                dwell_d = '0;
                if (ch_end) begin
                    sel_d = '0;
                    rnd_d = rnd_q + 1'b1;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            sel_q   <= '0;
            rnd_q   <= '0;
        end else begin
            dwell_q <= dwell_d;
            sel_q   <= sel_d;
            rnd_q   <= rnd_d;
        end
    end

    assign ch_sel_o    = sel_q;
    assign first_o     = (dwell_q == '0);
    assign round_cnt_o = rnd_q;
    assign wrap_o      = en_i && dwell_end && ch_end;
endmodule

// File: rtl/control_muxn_stream.sv
// rtl/control_muxn_stream.sv - round-robin channel sequencer holding idle channels in reset
module control_muxn_stream
    import control_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DWELL  = 4,
    parameter int RND_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    control_muxn_stream_if.slave  bus
);
    localparam int SEL_W = sel_w(NUM_CH);

    state_e            state_q, state_d;
    logic [RND_W-1:0]  rounds_lat_q, rounds_lat_d;
    logic              cnt_en, cnt_clr, cnt_wrap, cnt_first, last_round;
    logic [SEL_W-1:0]  cnt_sel;
    logic [RND_W-1:0]  cnt_round;

    // Abort outranks stall, so it also clears the counters while frozen.
    assign cnt_en     = (state_q == ST_RUN) && !bus.stall && !bus.abort;
    assign cnt_clr    = (state_q != ST_RUN) || bus.abort;
    assign last_round = cnt_wrap && (rounds_lat_q != '0) && (cnt_round == rounds_lat_q - 1'b1);

    control_mux_dwell_cnt #(
        .NUM_CH (NUM_CH),
        .DWELL  (DWELL),
        .RND_W  (RND_W)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (cnt_en),
        .clr_i       (cnt_clr),
        .ch_sel_o    (cnt_sel),
        .first_o     (cnt_first),
        .round_cnt_o (cnt_round),
        .wrap_o      (cnt_wrap)
    );

    always_comb begin
        state_d      = state_q;
        rounds_lat_d = rounds_lat_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d      = ST_RUN;
                rounds_lat_d = bus.cfg_rounds;
            end
            ST_RUN: if (bus.abort) begin
                state_d      = ST_IDLE;
                rounds_lat_d = '0;
            end else if (last_round) begin
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rounds_lat_q <= '0;
        end else begin
            state_q      <= state_d;
            rounds_lat_q <= rounds_lat_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.ch_sel   = cnt_sel;
    assign bus.ch_first = (state_q == ST_RUN) && cnt_first;
    assign bus.ch_reset = (state_q == ST_RUN) ? ~(NUM_CH'(1) << cnt_sel) : CH_RESET_ALL[NUM_CH-1:0];
endmodule

// File: tb/tb_control_muxn_stream.sv
// tb/tb_control_muxn_stream.sv - scoreboard bench for the N-way stream-mux reset controller
module tb_control_muxn_stream;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] rst;
        logic       first;
        logic       done;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    logic seen;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    exp_t t1 [9] = '{
        '{2'd0, 4'b1110, 1'b1, 1'b0}, '{2'd0, 4'b1110, 1'b0, 1'b0},
        '{2'd1, 4'b1101, 1'b1, 1'b0}, '{2'd1, 4'b1101, 1'b0, 1'b0},
        '{2'd2, 4'b1011, 1'b1, 1'b0}, '{2'd2, 4'b1011, 1'b0, 1'b0},
        '{2'd3, 4'b0111, 1'b1, 1'b0}, '{2'd3, 4'b0111, 1'b0, 1'b0},
        '{2'd0, 4'b1111, 1'b0, 1'b1}
    };

    always #5 clk = ~clk;

    control_muxn_stream_if #(.NUM_CH(4), .RND_W(8)) ia ();
    control_muxn_stream_if #(.NUM_CH(3), .RND_W(8)) ib ();

    control_muxn_stream #(.NUM_CH(4), .DWELL(2), .RND_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    control_muxn_stream #(.NUM_CH(3), .DWELL(1), .RND_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int sel, input bit first, input bit done);
        exp_t e;
        e.sel   = 2'(sel);
        e.rst   = done ? 4'hF : (4'hF & ~(4'h1 << sel));
        e.first = first;
        e.done  = done;
        return e;
    endfunction

    // Expected RUN cycles: entry i shows channel (i/dw)%nch; a stalled cycle repeats its entry.
    task automatic push_run(input bit b, input int nch, input int dw, input int n,
                            input int stall_cyc, input int stall_len);
        int i = 0;
        for (int c = 1; i < n; c++) begin
            if (b) q_b.push_back(mk((i / dw) % nch, (i % dw) == 0, 1'b0));
            else   q_a.push_back(mk((i / dw) % nch, (i % dw) == 0, 1'b0));
            if (!(c >= stall_cyc && c < stall_cyc + stall_len)) i++;
        end
    endtask

    task automatic push_done(input bit b);
        if (b) q_b.push_back(mk(0, 1'b0, 1'b1));
        else   q_a.push_back(mk(0, 1'b0, 1'b1));
    endtask

    task automatic start_run(input bit b, input logic [7:0] r);
        @(negedge clk);
        if (b) begin ib.start = 1'b1; ib.cfg_rounds = r; end
        else   begin ia.start = 1'b1; ia.cfg_rounds = r; end
        @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int c0, output int c);
        c = c0;
        while (!(b ? ib.done : ia.done) && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (ia.busy || ia.done)) begin
            if (q_a.size() == 0) chk("a_unexpected_output", {30'd0, ia.busy, ia.done}, 32'd0);
            else begin
                ea = q_a.pop_front();
                chk("a_stream", {ia.ch_sel, ia.ch_reset, ia.ch_first, ia.busy, ia.done},
                    {ea.sel, ea.rst, ea.first, ~ea.done, ea.done});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (ib.busy || ib.done)) begin
            if (q_b.size() == 0) chk("b_unexpected_output", {30'd0, ib.busy, ib.done}, 32'd0);
            else begin
                eb = q_b.pop_front();
                chk("b_stream", {ib.ch_sel, 1'b1, ib.ch_reset, ib.ch_first, ib.busy, ib.done},
                    {eb.sel, eb.rst, eb.first, ~eb.done, eb.done});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ia.start = 0; ia.cfg_rounds = 0; ia.stall = 0; ia.abort = 0;
        ib.start = 0; ib.cfg_rounds = 0; ib.stall = 0; ib.abort = 0;

        #3 rst_n = 1'b0;
        #1;
        chk("reset_a", {ia.ch_sel, ia.ch_reset, ia.ch_first, ia.busy, ia.done}, {2'd0, 4'hF, 3'b000});
        chk("reset_b", {ib.ch_sel, ib.ch_reset, ib.ch_first, ib.busy, ib.done}, {2'd0, 3'h7, 3'b000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single round
        foreach (t1[k]) q_a.push_back(t1[k]);
        start_run(1'b0, 8'd1);
        wait_done(1'b0, 1, cyc);
        chk("t1_done_cycle", cyc, 9);
        @(negedge clk);
        chk("t1_idle", {ia.busy, ia.done, ia.ch_reset}, {2'b00, 4'hF});
        chk("t1_drained", q_a.size(), 0);

        // two rounds with a three-cycle stall
        push_run(1'b0, 4, 2, 16, 3, 3);
        push_done(1'b0);
        start_run(1'b0, 8'd2);
        repeat (2) @(negedge clk);
        ia.stall = 1'b1;
        repeat (3) @(negedge clk);
        ia.stall = 1'b0;
        wait_done(1'b0, 6, cyc);
        chk("t2_done_cycle", cyc, 20);
        @(negedge clk);
        chk("t2_drained", q_a.size(), 0);

        // abort in cycle 4 of a three-round run
        push_run(1'b0, 4, 2, 4, 0, 0);
        start_run(1'b0, 8'd3);
        repeat (3) @(negedge clk);
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        chk("t3_abort_idle", {ia.busy, ia.done, ia.ch_reset}, {2'b00, 4'hF});
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= ia.done; end
        chk("t3_no_done", seen, 0);
        chk("t3_drained", q_a.size(), 0);

        // start pulses during RUN and DONE are ignored
        foreach (t1[k]) q_a.push_back(t1[k]);
        start_run(1'b0, 8'd1);
        @(negedge clk);
        ia.start = 1'b1; ia.cfg_rounds = 8'd3;
        @(negedge clk);
        ia.start = 1'b0;
        repeat (3) @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        wait_done(1'b0, 7, cyc);
        chk("t4_done_cycle", cyc, 9);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        chk("t4_idle_c10", {ia.busy, ia.done}, 2'b00);
        @(negedge clk);
        chk("t4_idle_c11", {ia.busy, ia.done}, 2'b00);
        chk("t4_drained", q_a.size(), 0);

        // continuous mode for 100 cycles, then abort
        push_run(1'b0, 4, 2, 100, 0, 0);
        start_run(1'b0, 8'd0);
        seen = 1'b0;
        repeat (99) begin seen |= ia.done; @(negedge clk); end
        seen |= ia.done;
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        chk("t5_no_done", seen, 0);
        chk("t5_abort_idle", {ia.busy, ia.done, ia.ch_reset}, {2'b00, 4'hF});
        chk("t5_drained", q_a.size(), 0);

        // asynchronous reset in the middle of a run
        push_run(1'b0, 4, 2, 3, 0, 0);
        start_run(1'b0, 8'd2);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_midrun_reset", {ia.ch_sel, ia.ch_reset, ia.ch_first, ia.busy, ia.done}, {2'd0, 4'hF, 3'b000});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen |= ia.done | ia.busy; end
        chk("t6_stays_idle", seen, 0);
        chk("t6_drained", q_a.size(), 0);

        // three channels, single-cycle dwell, two rounds
        push_run(1'b1, 3, 1, 6, 0, 0);
        push_done(1'b1);
        start_run(1'b1, 8'd2);
        wait_done(1'b1, 1, cyc);
        chk("t7_done_cycle", cyc, 7);
        @(negedge clk);
        chk("t7_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
